upsample1d_nearest: RTL and testbench
=====================================

UPSAMPLE1D_NEAREST -- requirements
Module: upsample1d_nearest

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8, meaning total input element width in bits.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 3, meaning input fractional bits.
REQ-003 SHALL have parameter DATA_IN_0_PARALLELISM_DIM_0, default 2, meaning elements per input beat (P).
REQ-004 SHALL have parameter SCALE_FACTOR, default 2, meaning upsampling factor S, legal range 2..16.
REQ-005 SHALL have parameters DATA_OUT_0_PRECISION_0 (default 8), DATA_OUT_0_PRECISION_1 (default 3) and DATA_OUT_0_PARALLELISM_DIM_0 (default 2); an elaboration-time assertion SHALL flag any out/in mismatch.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port data_in_0, input, P x DATA_IN_0_PRECISION_0: input beat.
REQ-009 SHALL have port data_in_0_valid, input, 1 bit; and port data_in_0_ready, output, 1 bit.
REQ-010 SHALL have port data_out_0, output, P x DATA_OUT_0_PRECISION_0: registered output beat.
REQ-011 SHALL have port data_out_0_valid, output, 1 bit; and port data_out_0_ready, input, 1 bit.

Function
REQ-012 SHALL transfer a beat on either interface only in a cycle where valid and ready are both high.
REQ-013 SHALL produce exactly S output beats per accepted input beat, in order, with no reordering or dropping.
REQ-014 Output beat b (0..S-1), element i SHALL equal the captured input element at index floor((b*P+i)/S), bit-exact with no arithmetic.
REQ-015 SHALL use a two-state FSM: IDLE (no beat held) and EMIT (beat held, beat counter b valid).
REQ-016 IDLE: data_in_0_ready=1 and data_out_0_valid=0; an accepted input SHALL load the hold register, set b=0, register output beat 0 and enter EMIT.
REQ-017 EMIT: data_out_0_valid=1; on an output handshake with b<S-1, b SHALL increment and the next beat SHALL be registered.
REQ-018 EMIT: data_in_0_ready SHALL equal data_out_0_ready when b=S-1, else 0 (combinational path from data_out_0_ready only).
REQ-019 On an output handshake at b=S-1: if an input handshake occurs in the same cycle, the block SHALL load the new beat, set b=0 and stay in EMIT (no bubble); otherwise it SHALL return to IDLE.
REQ-020 Latency SHALL be 1 cycle from input handshake to first data_out_0_valid; sustained throughput SHALL be one output beat per cycle.
REQ-021 While data_out_0_valid=1 and data_out_0_ready=0, data_out_0 and b SHALL hold stable.
REQ-022 The beat counter SHALL be ceil(log2(S)) bits wide and SHALL never exceed S-1.

Reset
REQ-023 rst low SHALL immediately force state IDLE, b=0, hold register and data_out_0 to all zeros, and data_out_0_valid=0, regardless of the clock.
REQ-024 Reset asserted mid-EMIT SHALL discard the held beat; no partial beat SHALL appear after deassertion.
REQ-025 The first input SHALL be accepted no earlier than the first rising clk edge after rst deasserts.

Configuration
REQ-026 Macro UPSAMPLE1D_ZERO_INSERT_EN: when defined, element i of beat b SHALL equal the input element at floor((b*P+i)/S) only if (b*P+i) mod S == 0, and zero otherwise (transposed-stride zero insertion).
REQ-027 When UPSAMPLE1D_ZERO_INSERT_EN is undefined, nearest-neighbour replication per REQ-014 SHALL apply and no zero-insertion logic SHALL be present.

Verification
REQ-028 P=2,S=2, input [3,5], out_ready=1 -> outputs [3,3] then [5,5] on consecutive cycles, then valid=0.
REQ-029 P=2,S=2, inputs [3,5],[7,9] back-to-back, out_ready=1 -> [3,3],[5,5],[7,7],[9,9] in 4 consecutive cycles, in_ready high only on cycles with b=1.
REQ-030 P=2,S=2, input [3,5], out_ready low 3 cycles after first valid -> [3,3] held stable 3 cycles, then [3,3],[5,5] delivered.
REQ-031 P=2,S=2, UPSAMPLE1D_ZERO_INSERT_EN defined, input [3,5] -> outputs [3,0] then [5,0].
REQ-032 P=2,S=4, rst pulsed low while b=1 of input [3,5] -> valid drops asynchronously, data_out_0=[0,0]; next input [6,8] -> [6,6],[6,6],[8,8],[8,8].

Source files
------------

// File: rtl/upsample1d_nearest.sv
// upsample1d_nearest: 1-D upsampler with a valid/ready stream on each side.
// Every accepted input beat of P elements becomes SCALE_FACTOR output beats.
// Element i of output beat b is input element floor((b*P+i)/S), copied
// bit-exact (nearest-neighbour replication).
// Optional build macro UPSAMPLE1D_ZERO_INSERT_EN: elements whose position
// (b*P+i) is not a multiple of S read as zero instead (transposed-stride
// zero insertion). Leaving the macro undefined builds pure replication.
// Reset rst is asynchronous and active low.

module upsample1d_nearest #(
  parameter int DATA_IN_0_PRECISION_0        = 8,
  parameter int DATA_IN_0_PRECISION_1        = 3,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 2,
  parameter int SCALE_FACTOR                 = 2,
  parameter int DATA_OUT_0_PRECISION_0       = 8,
  parameter int DATA_OUT_0_PRECISION_1       = 3,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 2
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PRECISION_0-1:0]   data_in_0,
  input  logic                                                     data_in_0_valid,
  output logic                                                     data_in_0_ready,
  output logic [DATA_OUT_0_PARALLELISM_DIM_0*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                                     data_out_0_valid,
  input  logic                                                     data_out_0_ready
);

  localparam int P  = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int S  = SCALE_FACTOR;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(S - 1);

  // The output format must be identical to the input format, since elements
  // are copied without any arithmetic; anything else is a build error.
  if ((DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0) ||
      (DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) ||
      (DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0)) begin : g_bad_format
    $error("upsample1d_nearest: output format must match input format");
  end

  if ((SCALE_FACTOR < 2) || (SCALE_FACTOR > 16)) begin : g_bad_scale
    $error("upsample1d_nearest: SCALE_FACTOR must be in 2..16");
  end

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   beat;
  logic [P*W-1:0]  hold_q;
  logic [P*W-1:0]  out_q;
  logic            out_valid_q;

  logic            at_last;
  logic            in_hs;
  logic            out_hs;
  logic [CW-1:0]   next_beat;

  // Builds output beat b from a held input beat. The source index is always
  // below P because b <= S-1 and i <= P-1.
  function automatic logic [P*W-1:0] build_beat(input logic [P*W-1:0] src,
                                                input logic [CW-1:0]  b);
    logic [P*W-1:0] res;
    int             pos;
    int             idx;
    res = '0;
    for (int i = 0; i < P; i++) begin
      pos = int'(b) * P + i;
      idx = pos / S;
`ifdef UPSAMPLE1D_ZERO_INSERT_EN
      if ((pos % S) == 0) begin
        res[i*W +: W] = src[idx*W +: W];
      end
`else
      res[i*W +: W] = src[idx*W +: W];
`endif
    end
    return res;
  endfunction

  // A new beat may enter when nothing is held, or when the last replica of
  // the current beat leaves this cycle; that second path is what allows
  // back-to-back input beats with no bubble on the output.
  assign at_last         = (beat == LAST_BEAT);
  assign data_in_0_ready = (state == IDLE) || (at_last && data_out_0_ready);
  assign in_hs           = data_in_0_valid && data_in_0_ready;
  assign out_hs          = out_valid_q && data_out_0_ready;
  assign next_beat       = beat + CW'(1);

  assign data_out_0       = out_q;
  assign data_out_0_valid = out_valid_q;

  // Control FSM with the hold register and the registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      beat        <= '0;
      hold_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            hold_q      <= data_in_0;
            beat        <= '0;
            out_q       <= build_beat(data_in_0, '0);
            out_valid_q <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (at_last) begin
              if (in_hs) begin
                hold_q      <= data_in_0;
                beat        <= '0;
                out_q       <= build_beat(data_in_0, '0);
                out_valid_q <= 1'b1;
              end else begin
                beat        <= '0;
                out_valid_q <= 1'b0;
                state       <= IDLE;
              end
            end else begin
              beat  <= next_beat;
              out_q <= build_beat(hold_q, next_beat);
            end
          end
        end
        default: begin
          state       <= IDLE;
          beat        <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upsample1d_nearest.sv
// tb_upsample1d_nearest: scoreboard bench for upsample1d_nearest.
// Two instances share clock and reset: u_s2 (P=2, S=2) and u_s4 (P=2, S=4).
// Expected output beats are pushed when an input beat is offered and popped
// when the DUT hands an output beat over. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge.

module tb_upsample1d_nearest;

  localparam int S_A = 2;
  localparam int S_B = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [15:0] a_in;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [15:0] a_out;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [15:0] b_in;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_out;
  logic        b_out_valid;
  logic        b_out_ready;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int          a_cnt = 0;
  int          check_count = 0;
  int          pass_count = 0;

`ifdef UPSAMPLE1D_ZERO_INSERT_EN
  localparam logic [15:0] R028_BEAT0 = 16'h0003;
  localparam logic [15:0] R028_BEAT1 = 16'h0005;
`else
  localparam logic [15:0] R028_BEAT0 = 16'h0303;
  localparam logic [15:0] R028_BEAT1 = 16'h0505;
`endif

  upsample1d_nearest #(
    .SCALE_FACTOR(S_A)
  ) u_s2 (
    .clk              (clk),
    .rst              (rst_n),
    .data_in_0        (a_in),
    .data_in_0_valid  (a_in_valid),
    .data_in_0_ready  (a_in_ready),
    .data_out_0       (a_out),
    .data_out_0_valid (a_out_valid),
    .data_out_0_ready (a_out_ready)
  );

  upsample1d_nearest #(
    .SCALE_FACTOR(S_B)
  ) u_s4 (
    .clk              (clk),
    .rst              (rst_n),
    .data_in_0        (b_in),
    .data_in_0_valid  (b_in_valid),
    .data_in_0_ready  (b_in_ready),
    .data_out_0       (b_out),
    .data_out_0_valid (b_out_valid),
    .data_out_0_ready (b_out_ready)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model: beat b of an upsampled two-element input.
  function automatic logic [15:0] model_beat(input logic [15:0] d, input int b, input int s);
    logic [15:0] res;
    int          pos;
    res = '0;
    for (int i = 0; i < 2; i++) begin
      pos = b * 2 + i;
`ifdef UPSAMPLE1D_ZERO_INSERT_EN
      if ((pos % s) == 0) res[i*8 +: 8] = d[(pos / s)*8 +: 8];
`else
      res[i*8 +: 8] = d[(pos / s)*8 +: 8];
`endif
    end
    return res;
  endfunction

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Offers one beat to u_s2 and waits (bounded) for its handshake.
  task automatic apply_stimulus_a(input logic [15:0] d);
    logic hs;
    int   n;
    a_in       = d;
    a_in_valid = 1'b1;
    for (int b = 0; b < S_A; b++) exp_a.push_back(model_beat(d, b, S_A));
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    a_in_valid = 1'b0;
    if (!hs) check_output("a_in_handshake_timeout", 16'(hs), 16'd1);
  endtask

  // Offers one beat to u_s4 and waits (bounded) for its handshake.
  task automatic apply_stimulus_b(input logic [15:0] d);
    logic hs;
    int   n;
    b_in       = d;
    b_in_valid = 1'b1;
    for (int b = 0; b < S_B; b++) exp_b.push_back(model_beat(d, b, S_B));
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    b_in_valid = 1'b0;
    if (!hs) check_output("b_in_handshake_timeout", 16'(hs), 16'd1);
  endtask

  task automatic wait_drain_a();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || a_out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("a_drain_left", 16'(exp_a.size()), 16'd0);
  endtask

  task automatic wait_drain_b();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || b_out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("b_drain_left", 16'(exp_b.size()), 16'd0);
  endtask

  // Scoreboard and in_ready monitor for u_s2.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_cnt = 0;
      exp_a.delete();
    end else begin
      check_output("a_in_ready", 16'(a_in_ready),
                   16'(!a_out_valid || ((a_cnt == S_A - 1) && a_out_ready)));
      if (a_out_valid) begin
        if (exp_a.size() == 0) check_output("a_extra_beat", 16'(a_out_valid), 16'd0);
        else if (a_out_ready) begin
          check_output("a_beat", a_out, exp_a.pop_front());
          a_cnt = (a_cnt + 1) % S_A;
        end else check_output("a_stall_hold", a_out, exp_a[0]);
      end
    end
  end

  // Scoreboard for u_s4.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_b.delete();
    end else if (b_out_valid) begin
      if (exp_b.size() == 0) check_output("b_extra_beat", 16'(b_out_valid), 16'd0);
      else if (b_out_ready) check_output("b_beat", b_out, exp_b.pop_front());
      else check_output("b_stall_hold", b_out, exp_b[0]);
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    a_in        = '0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_in        = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    check_output("rst_a_valid", 16'(a_out_valid), 16'd0);
    check_output("rst_a_data", a_out, 16'h0000);
    check_output("rst_a_in_ready", 16'(a_in_ready), 16'd1);
    check_output("rst_b_valid", 16'(b_out_valid), 16'd0);
    check_output("rst_b_data", b_out, 16'h0000);
    #14 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat [3,5] with the sink always ready.
    apply_stimulus_a({8'd5, 8'd3});
    check_output("r028_valid0", 16'(a_out_valid), 16'd1);
    check_output("r028_beat0", a_out, R028_BEAT0);
    @(posedge clk);
    #1;
    check_output("r028_valid1", 16'(a_out_valid), 16'd1);
    check_output("r028_beat1", a_out, R028_BEAT1);
    @(posedge clk);
    #1;
    check_output("r028_idle", 16'(a_out_valid), 16'd0);

    // Back-to-back beats [3,5] then [7,9].
    apply_stimulus_a({8'd5, 8'd3});
    apply_stimulus_a({8'd9, 8'd7});
    check_output("r029_valid2", 16'(a_out_valid), 16'd1);
    @(posedge clk);
    #1;
    check_output("r029_valid3", 16'(a_out_valid), 16'd1);
    @(posedge clk);
    #1;
    check_output("r029_idle", 16'(a_out_valid), 16'd0);

    // Sink stalls for three cycles after the first output is presented.
    a_out_ready = 1'b0;
    apply_stimulus_a({8'd5, 8'd3});
    repeat (3) @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    wait_drain_a();

    // Random beats with a randomly stalling sink.
    fork
      begin
        for (int k = 0; k < 6; k++) apply_stimulus_a(16'($urandom));
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          a_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    a_out_ready = 1'b1;
    wait_drain_a();

    // S=4: reset asserted while beat 1 of [3,5] is presented.
    apply_stimulus_b({8'd5, 8'd3});
    @(posedge clk);
    #1;
    check_output("r032_b1_valid", 16'(b_out_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("r032_rst_valid", 16'(b_out_valid), 16'd0);
    check_output("r032_rst_data", b_out, 16'h0000);
    @(posedge clk);
    #1;
    check_output("r032_rst_hold", 16'(b_out_valid), 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("r032_no_partial_valid", 16'(b_out_valid), 16'd0);
    check_output("r032_no_partial_data", b_out, 16'h0000);
    apply_stimulus_b({8'd8, 8'd6});
    wait_drain_b();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
